// File: rtl/dct_pkg.sv
// Shared constants, bank-state type and address/saturation helpers for the DCT transpose buffer.
package dct_pkg;

  localparam int unsigned DctPoints     = 8;
  localparam int unsigned DctLog2Points = 3;
  localparam int unsigned DctDinWidth   = 19;
  localparam int unsigned DctDoutWidth  = 15;
  localparam int unsigned SatMaxWidth   = 32;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankReading
  } bank_state_e;

  function automatic logic bank_holds_data(input bank_state_e st);
    return (st == BankFull) || (st == BankReading);
  endfunction

  // din is sign-extended to SatMaxWidth; clip when bits [in_w-1:out_w-1] disagree with the sign.
  function automatic logic [SatMaxWidth-1:0] sat_clip(input logic [SatMaxWidth-1:0] din,
                                                      input int unsigned in_w,
                                                      input int unsigned out_w);
    logic                   sign;
    logic [SatMaxWidth-1:0] mask;
    logic [SatMaxWidth-1:0] masked;
    logic [SatMaxWidth-1:0] max_pos;
    logic                   clip;
    sign    = |(din & (32'd1 << (in_w - 1)));
    mask    = ((32'd1 << in_w) - 32'd1) & ~((32'd1 << (out_w - 1)) - 32'd1);
    masked  = din & mask;
    clip    = sign ? (masked != mask) : (masked != '0);
    max_pos = (32'd1 << (out_w - 1)) - 32'd1;
    if (!clip) begin
      return din;
    end
    return sign ? ~max_pos : max_pos;
  endfunction

  // Column-major offset: (cnt mod N) * N + cnt / N.
  function automatic logic [SatMaxWidth-1:0] transpose_addr(input logic [SatMaxWidth-1:0] cnt,
                                                            input int unsigned log2n);
    logic [SatMaxWidth-1:0] n_mask;
    n_mask = (32'd1 << log2n) - 32'd1;
    return ((cnt & n_mask) << log2n) | ((cnt >> log2n) & n_mask);
  endfunction

endpackage

// File: rtl/dct_tp_ram.sv
// Simple dual-port RAM holding both transpose banks: one write port, one registered read port.
module dct_tp_ram #(
  parameter int unsigned C_DEPTH      = 128,
  parameter int unsigned C_ADDR_WIDTH = 7,
  parameter int unsigned C_DATA_WIDTH = 19
) (
  input  logic                    CLK,
  input  logic                    we,
  input  logic [C_ADDR_WIDTH-1:0] waddr,
  input  logic [C_DATA_WIDTH-1:0] wdata,
  input  logic [C_ADDR_WIDTH-1:0] raddr,
  output logic [C_DATA_WIDTH-1:0] rdata
);

  logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose memory between row and column DCT stages: row-major in, column-major out,
// with write flow control, read backpressure, programmable read gap and optional saturation.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int unsigned C_POINTS      = 8,
  parameter int unsigned C_LOG2_POINTS = 3,
  parameter int unsigned C_DIN_WIDTH   = 19,
  parameter int unsigned C_DOUT_WIDTH  = 15,
  parameter int unsigned C_SATURATE    = 1,
  parameter int unsigned C_READ_GAP    = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [C_DIN_WIDTH-1:0]  DIN,
  input  logic                    ND,
  output logic                    RFD,
  input  logic                    CRFD,
  output logic [C_DOUT_WIDTH-1:0] DOUT,
  output logic                    RDY,
  output logic                    OVERFLOW,
  output logic [1:0]              BANKS_FULL
);

  localparam int unsigned NumCells = C_POINTS * C_POINTS;
  localparam int unsigned CntW     = 2 * C_LOG2_POINTS;
  localparam int unsigned AddrW    = CntW + 1;
  localparam int unsigned GapW     = (C_READ_GAP > 0) ? $clog2(C_READ_GAP + 1) : 1;

  bank_state_e             bank_q [2];
  bank_state_e             bank_d [2];
  logic                    wr_bank_q, rd_bank_q;
  logic [CntW-1:0]         wr_cnt_q, rd_cnt_q;
  logic [GapW-1:0]         gap_q;
  logic                    ovf_q;
  logic [1:0]              banks_full_q;
  logic [AddrW-1:0]        rd_addr_q;
  logic                    rd_v0_q, rd_v1_q, rdy_q;
  logic [C_DOUT_WIDTH-1:0] dout_q, sat_val;
  logic [C_DIN_WIDTH-1:0]  ram_rdata;
  logic                    wr_en, wr_last, rd_issue, rd_last;

  assign RFD      = !bank_holds_data(bank_q[wr_bank_q]);
  assign wr_en    = ND && RFD;
  assign wr_last  = &wr_cnt_q;
  assign rd_issue = bank_holds_data(bank_q[rd_bank_q]) && CRFD && (gap_q == '0);
  assign rd_last  = &rd_cnt_q;

  // Fill and free always target different banks, so both updates can land in one cycle.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) begin
      if (wr_last) bank_d[wr_bank_q] = BankFull;
      else         bank_d[wr_bank_q] = BankFilling;
    end
    if (rd_issue) begin
      if (rd_last) bank_d[rd_bank_q] = BankEmpty;
      else         bank_d[rd_bank_q] = BankReading;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bank_q[0]    <= BankEmpty;
      bank_q[1]    <= BankEmpty;
      banks_full_q <= 2'd0;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      banks_full_q <= {1'b0, bank_holds_data(bank_d[0])} + {1'b0, bank_holds_data(bank_d[1])};
      if (ND && !RFD) begin
        ovf_q <= 1'b1;
      end
      if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + CntW'(1);
        if (wr_last) begin
          wr_bank_q <= ~wr_bank_q;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      gap_q     <= '0;
      rd_addr_q <= '0;
      rd_v0_q   <= 1'b0;
      rd_v1_q   <= 1'b0;
      rdy_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      rd_v0_q <= rd_issue;
      rd_v1_q <= rd_v0_q;
      rdy_q   <= rd_v1_q;
      if (rd_issue) begin
        rd_addr_q <= {rd_bank_q, CntW'(transpose_addr(32'(rd_cnt_q), C_LOG2_POINTS))};
        rd_cnt_q  <= rd_cnt_q + CntW'(1);
        gap_q     <= GapW'(C_READ_GAP);
        if (rd_last) begin
          rd_bank_q <= ~rd_bank_q;
        end
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GapW'(1);
      end
      if (rd_v1_q) begin
        dout_q <= sat_val;
      end
    end
  end

  always_comb begin
    sat_val = '0;
    if (C_SATURATE != 0) begin
      sat_val = C_DOUT_WIDTH'(sat_clip(32'($signed(ram_rdata)), C_DIN_WIDTH, C_DOUT_WIDTH));
    end else begin
      sat_val = ram_rdata[C_DOUT_WIDTH-1:0];
    end
  end

  dct_tp_ram #(
    .C_DEPTH      (2 * NumCells),
    .C_ADDR_WIDTH (AddrW),
    .C_DATA_WIDTH (C_DIN_WIDTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata (DIN),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign DOUT       = dout_q;
  assign RDY        = rdy_q;
  assign OVERFLOW   = ovf_q;
  assign BANKS_FULL = banks_full_q;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: block-level transpose/saturation model plus directed and random
// traffic; a second instance exercises the programmable read gap.
module tb_dct_transpose_buffer;

  localparam int N  = 8;
  localparam int NN = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic [18:0] din, din_g;
  logic        nd, nd_g, crfd, crfd_g;
  logic [14:0] dout, dout_g;
  logic        rdy, rdy_g, rfd, rfd_g, ovf, ovf_g;
  logic [1:0]  banks_full, banks_full_g;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int exp_q[$];
  int blk[$];
  int got_v[$], got_c[$];
  int g_v[$], g_c[$];
  logic [2:0] crfd_h = '0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dct_transpose_buffer #(
    .C_POINTS(8), .C_LOG2_POINTS(3), .C_DIN_WIDTH(19), .C_DOUT_WIDTH(15),
    .C_SATURATE(1), .C_READ_GAP(0)
  ) dut (
    .CLK(CLK), .RST(RST), .DIN(din), .ND(nd), .RFD(rfd), .CRFD(crfd), .DOUT(dout), .RDY(rdy),
    .OVERFLOW(ovf), .BANKS_FULL(banks_full)
  );

  dct_transpose_buffer #(
    .C_POINTS(8), .C_LOG2_POINTS(3), .C_DIN_WIDTH(19), .C_DOUT_WIDTH(15),
    .C_SATURATE(1), .C_READ_GAP(10)
  ) dut_g (
    .CLK(CLK), .RST(RST), .DIN(din_g), .ND(nd_g), .RFD(rfd_g), .CRFD(crfd_g), .DOUT(dout_g),
    .RDY(rdy_g), .OVERFLOW(ovf_g), .BANKS_FULL(banks_full_g)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sat15(input int v);
    if (v > 16383) return 16383;
    if (v < -16384) return -16384;
    return v;
  endfunction

  // Model: collect a full row-major block, then queue it in column-major order.
  function automatic void push_sample(input int v);
    blk.push_back(v);
    if (blk.size() == NN) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < N; r++)
          exp_q.push_back(sat15(blk[r * N + c]));
      blk.delete();
    end
  endfunction

  function automatic int rand_din();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 524287)) - 262144;
    return int'($urandom_range(0, 40000)) - 20000;
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      check("rfd_vs_banks_full", int'(rfd), int'(banks_full != 2'd2));
      if (rdy) begin
        // An output now needs CRFD=1 three cycles back (issue, RAM, output register).
        check("crfd_backpressure", int'(crfd_h[2]), 1);
        got_v.push_back(int'($signed(dout)));
        got_c.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: RDY=1 with DOUT=%0d, expected no output", $signed(dout));
        end else begin
          check("dout", int'($signed(dout)), exp_q.pop_front());
        end
      end
    end
    crfd_h <= {crfd_h[1:0], crfd};
  end

  always @(negedge CLK) begin
    if (!RST && rdy_g) begin
      g_v.push_back(int'($signed(dout_g)));
      g_c.push_back(cyc);
    end
  end

  task automatic drive(input logic n, input int v, input logic c);
    nd   = n;
    din  = 19'(v);
    crfd = c;
    @(posedge CLK);
    #1;
  endtask

  // Well-behaved producer: only asserts ND when RFD is high.
  task automatic send(input int v, input logic c);
    logic acc;
    acc = rfd;
    drive(acc, v, c);
    if (acc) push_sample(v);
  endtask

  task automatic drain(input int bound, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      drive(1'b0, 0, 1'b1);
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) drive(1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    nd  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    blk.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_edge, k, drops, v;
    RST = 1'b1; nd = 1'b0; din = '0; crfd = 1'b1;
    nd_g = 1'b0; din_g = '0; crfd_g = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rdy", int'(rdy), 0);
    check("rst_rfd", int'(rfd), 1);
    check("rst_ovf", int'(ovf), 0);
    check("rst_banks_full", int'(banks_full), 0);
    check("rst_dout", int'(dout), 0);
    RST = 1'b0;
    drive(1'b0, 0, 1'b1);

    // A: one ramp block
    got_v.delete(); got_c.delete();
    for (int i = 0; i < NN; i++) send(i, 1'b1);
    last_edge = cyc;
    drain(200, "a_drain");
    check("a_count", got_v.size(), NN);
    if (got_v.size() == NN) begin
      check("a_first_latency", got_c[0] - last_edge, 3);
      check("a_contiguous", got_c[NN-1] - got_c[0], NN - 1);
      check("a_dout1", got_v[1], 8);
      check("a_dout8", got_v[8], 1);
      check("a_dout63", got_v[63], 63);
    end

    // B: two back-to-back blocks
    got_v.delete(); got_c.delete();
    drops = 0;
    for (int i = 0; i < 2 * NN; i++) begin
      if (!rfd) drops++;
      send(i * 7 - 300, 1'b1);
    end
    check("b_rfd_held", drops, 0);
    drain(300, "b_drain");
    check("b_count", got_v.size(), 2 * NN);
    if (got_v.size() == 2 * NN) check("b_contiguous", got_c[2*NN-1] - got_c[0], 2 * NN - 1);

    // C: no downstream acceptance, 130 samples forced in
    got_v.delete(); got_c.delete();
    for (int i = 0; i < 130; i++) begin
      if (i < 2 * NN) push_sample(i - 65);
      drive(1'b1, i - 65, 1'b0);
    end
    check("c_rfd_low", int'(rfd), 0);
    check("c_overflow", int'(ovf), 1);
    check("c_banks_full", int'(banks_full), 2);
    check("c_no_output", got_v.size(), 0);
    drain(400, "c_drain");
    check("c_count", got_v.size(), 2 * NN);
    check("c_overflow_sticky", int'(ovf), 1);
    do_reset();
    check("c_overflow_cleared", int'(ovf), 0);

    // D: saturation corners
    got_v.delete(); got_c.delete();
    for (int i = 0; i < NN; i++) begin
      v = (i == 0) ? 20000 : (i == 1) ? -20000 : (i == 2) ? -5 : rand_din();
      send(v, 1'b1);
    end
    drain(200, "d_drain");
    if (got_v.size() == NN) begin
      check("d_sat_pos", got_v[0], 16383);
      check("d_sat_neg", got_v[8], -16384);
      check("d_small_neg", got_v[16], -5);
    end else begin
      check("d_count", got_v.size(), NN);
    end

    // E: random traffic with random backpressure
    for (int i = 0; i < 800; i++)
      if ($urandom_range(0, 9) < 7) send(rand_din(), 1'($urandom_range(0, 9) < 6));
      else drive(1'b0, 0, 1'($urandom_range(0, 9) < 6));
    k = 0;
    while (blk.size() != 0 && k < 300) begin
      send(rand_din(), 1'b1);
      k++;
    end
    drain(3000, "e_drain");
    check("e_no_overflow", int'(ovf), 0);

    // F: reset in the middle of reading a block
    got_v.delete(); got_c.delete();
    for (int i = 0; i < NN; i++) send(500 + i, 1'b1);
    k = 0;
    while (got_v.size() < 30 && k < 200) begin
      drive(1'b0, 0, 1'b1);
      k++;
    end
    check("f_progress", got_v.size(), 30);
    check("f_rdy_before", int'(rdy), 1);
    #1 RST = 1'b1;
    #1;
    check("f_rst_rdy", int'(rdy), 0);
    check("f_rst_rfd", int'(rfd), 1);
    check("f_rst_banks_full", int'(banks_full), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete(); blk.delete();
    got_v.delete(); got_c.delete();
    for (int i = 0; i < NN; i++) send(900 - 3 * i, 1'b1);
    last_edge = cyc;
    drain(200, "f_drain");
    check("f_count", got_v.size(), NN);
    if (got_v.size() == NN) check("f_first_latency", got_c[0] - last_edge, 3);

    // G: read gap of 10 on the second instance
    for (int i = 0; i < NN; i++) begin
      nd_g = 1'b1; din_g = 19'(i);
      @(posedge CLK);
      #1;
    end
    nd_g = 1'b0;
    last_edge = cyc;
    k = 0;
    while (g_v.size() < NN && k < NN * 11 + 50) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("g_count", g_v.size(), NN);
    if (g_v.size() == NN) begin
      check("g_first_latency", g_c[0] - last_edge, 3);
      check("g_order0", g_v[0], 0);
      for (int i = 1; i < NN; i++) begin
        check("g_spacing", g_c[i] - g_c[i-1], 11);
        check("g_order", g_v[i], (i % N) * N + i / N);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
